usb_ft_tx_ctrl: RTL and testbench

//  FPGA-side write master for the FT600/601 245 synchronous FIFO interface, in the USB clock domain.

---
 rtl/usb_pkg.sv | 8 +
 rtl/usb_skid_buf.sv | 69 ++++++
 rtl/usb_ft_tx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_usb_ft_tx_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared state encoding and FTDI bus constants for the FT600/601 write path.
package usb_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, GAP, TURN} ft_state_e;

  localparam int FT_DATA_W    = 32;
  localparam int FT_BE_W      = 4;
  localparam int FT_BUF_BYTES = 1024;
endpackage

// File: rtl/usb_skid_buf.sv
// Two-entry valid/ready buffer carrying {be, data}; ready is registered and equals !full.
module usb_skid_buf
  import usb_pkg::*;
#(
  parameter int W = FT_DATA_W + FT_BE_W
) (
  input  logic         iCLK,
  input  logic         iRESET,
  input  logic         iVALID,
  output logic         oREADY,
  input  logic [W-1:0] iDATA,
  output logic         oVALID,
  input  logic         iPOP,
  output logic [W-1:0] oDATA
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  assign push = iVALID & ready_q;
  assign pop  = iPOP & (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = iDATA;
        else               tail_d = iDATA;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // occupancy unchanged; the incoming word lands behind whatever remains
        if (cnt_q == 2'd1) begin
          head_d = iDATA;
        end else begin
          head_d = tail_q;
          tail_d = iDATA;
        end
      end
      default: ;
    endcase
    ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign oREADY = ready_q;
  assign oVALID = (cnt_q != 2'd0);
  assign oDATA  = head_q;
endmodule

// File: rtl/usb_ft_tx_ctrl.sv
// FT600/601 245 synchronous FIFO write master with burst splitting.
// USB_TX_PATTERN_EN replaces the upstream stream with an internal counting source.
//
// state | meaning
// IDLE  | bus released, waiting for buffered data and TXE_N low
// WRITE | WR_N low, one word presented per cycle
// GAP   | WR_N high between bursts while the FTDI drains its 1 kB buffer
// TURN  | one bus-hold cycle before releasing the pads
module usb_ft_tx_ctrl
  import usb_pkg::*;
#(
  parameter  int DATA_W    = FT_DATA_W,
  parameter  int BURST_LEN = FT_BUF_BYTES / (FT_DATA_W / 8),
  parameter  int GAP_CYC   = 2,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [BE_W-1:0]   iBE,
  input  logic              iTXE_N,
  output logic [DATA_W-1:0] oDATA,
  output logic [BE_W-1:0]   oBE,
  output logic              oDATA_OE,
  output logic              oWR_N,
  output logic              oOE_N,
  output logic              oRD_N,
  output logic              oBUSY
);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  ft_state_e                state_q, state_d;
  logic [CNT_W-1:0]         bcnt_q, bcnt_d;
  logic [3:0]               gcnt_q, gcnt_d;
  logic                     wr_n_q, wr_n_d, oe_q, oe_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [BE_W-1:0]          be_q, be_d;

  logic                     push_valid, buf_ready, buf_valid, buf_pop, xfer;
  logic [BE_W+DATA_W-1:0]   push_word, buf_word;

`ifdef USB_TX_PATTERN_EN
  logic [DATA_W-1:0] pat_q;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)         pat_q <= '0;
    else if (buf_ready) pat_q <= pat_q + DATA_W'(1);
  end

  assign push_valid = 1'b1;
  assign push_word  = {{BE_W{1'b1}}, pat_q};
  assign oREADY     = 1'b0;
`else
  assign push_valid = iVALID;
  assign push_word  = {iBE, iDATA};
  assign oREADY     = buf_ready;
`endif

  usb_skid_buf #(.W(BE_W + DATA_W)) u_skid (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iVALID (push_valid),
    .oREADY (buf_ready),
    .iDATA  (push_word),
    .oVALID (buf_valid),
    .iPOP   (buf_pop),
    .oDATA  (buf_word)
  );

  assign xfer = ~wr_n_q & ~iTXE_N;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    wr_n_d  = wr_n_q;
    oe_d    = oe_q;
    data_d  = data_q;
    be_d    = be_q;
    buf_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_valid && !iTXE_N) begin
          state_d          = WRITE;
          {be_d, data_d}   = buf_word;
          buf_pop          = 1'b1;
          wr_n_d           = 1'b0;
          oe_d             = 1'b1;
          bcnt_d           = '0;
        end
      end
      WRITE: begin
        if (xfer) begin
          bcnt_d = bcnt_q + CNT_W'(1);
          if (bcnt_q == CNT_W'(BURST_LEN - 1)) begin
            state_d = GAP;
            wr_n_d  = 1'b1;
            gcnt_d  = 4'(GAP_CYC - 1);
          end else if (buf_valid) begin
            {be_d, data_d} = buf_word;
            buf_pop        = 1'b1;
          end else begin
            state_d = TURN;
            wr_n_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt_q != 4'd0) begin
          gcnt_d = gcnt_q - 4'd1;
        end else if (buf_valid && !iTXE_N) begin
          state_d        = WRITE;
          {be_d, data_d} = buf_word;
          buf_pop        = 1'b1;
          wr_n_d         = 1'b0;
          bcnt_d         = '0;
        end else begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      end
      TURN: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        wr_n_d  = 1'b1;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      gcnt_q  <= 4'd0;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      wr_n_q  <= wr_n_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign oDATA    = data_q;
  assign oBE      = be_q;
  assign oDATA_OE = oe_q;
  assign oWR_N    = wr_n_q;
  assign oOE_N    = 1'b1;
  assign oRD_N    = 1'b1;
  assign oBUSY    = (state_q != IDLE) | buf_valid;
endmodule

// File: tb/tb_usb_ft_tx_ctrl.sv
// Directed bench for usb_ft_tx_ctrl: vector table plus multi-cycle burst, stall and reset sequences.
module tb_usb_ft_tx_ctrl;
  logic        iCLK = 1'b0;
  logic        iRESET = 1'b1;
  logic        iVALID = 1'b0;
  logic        oREADY;
  logic [31:0] iDATA = '0;
  logic [3:0]  iBE = 4'hF;
  logic        iTXE_N = 1'b0;
  logic [31:0] oDATA;
  logic [3:0]  oBE;
  logic        oDATA_OE, oWR_N, oOE_N, oRD_N, oBUSY;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] xq[$];
  int          bursts[$];
  int          gaps[$];
  logic [35:0] src_q[$];
  int          run_len = 0;
  int          hi_len  = 0;
  bit          in_gap  = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  be;
    logic        txe;
    logic        e_wr;
    logic        e_oe;
    logic [31:0] e_d;
    logic [3:0]  e_be;
    logic        e_rdy;
    logic        e_busy;
  } vec_t;

  usb_ft_tx_ctrl dut (
    .iCLK     (iCLK),
    .iRESET   (iRESET),
    .iVALID   (iVALID),
    .oREADY   (oREADY),
    .iDATA    (iDATA),
    .iBE      (iBE),
    .iTXE_N   (iTXE_N),
    .oDATA    (oDATA),
    .oBE      (oBE),
    .oDATA_OE (oDATA_OE),
    .oWR_N    (oWR_N),
    .oOE_N    (oOE_N),
    .oRD_N    (oRD_N),
    .oBUSY    (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  // Bus monitor: values at the falling edge are what the FTDI sees at the next rising edge.
  always @(negedge iCLK) begin
    if (iRESET) begin
      run_len = 0;
      hi_len  = 0;
      in_gap  = 0;
    end else if (!oWR_N) begin
      if (in_gap && hi_len > 0) gaps.push_back(hi_len);
      in_gap = 0;
      hi_len = 0;
      if (!iTXE_N) begin
        xq.push_back({oBE, oDATA});
        run_len++;
      end
    end else begin
      if (run_len > 0) begin
        bursts.push_back(run_len);
        run_len = 0;
        in_gap  = 1;
        hi_len  = 0;
      end
      if (in_gap) begin
        if (oDATA_OE) hi_len++;
        else          in_gap = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; offers the head of src_q and advances one cycle.
  task automatic cycle();
    bit rdy;
    if (src_q.size() > 0) begin
      iVALID = 1'b1;
      {iBE, iDATA} = src_q[0];
      rdy = oREADY;
    end else begin
      iVALID = 1'b0;
      rdy = 1'b0;
    end
    @(posedge iCLK); #1;
    if (rdy) void'(src_q.pop_front());
  endtask

  task automatic drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      cycle();
      if (src_q.size() == 0 && !oBUSY) begin
        ok = 1'b1;
        break;
      end
    end
    iVALID = 1'b0;
  endtask

  initial begin
    vec_t tv[14];
    int   bx, bb, bg, bad, nxt, c;
    bit   ok;

    tv[0]  = '{1'b1, 32'h11111111, 4'hF, 1'b0, 1'b1, 1'b0, 32'h00000000, 4'h0, 1'b1, 1'b1};
    tv[1]  = '{1'b1, 32'h22222222, 4'hF, 1'b0, 1'b0, 1'b1, 32'h11111111, 4'hF, 1'b1, 1'b1};
    tv[2]  = '{1'b1, 32'h33333333, 4'hF, 1'b0, 1'b0, 1'b1, 32'h22222222, 4'hF, 1'b1, 1'b1};
    tv[3]  = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0, 1'b1, 32'h33333333, 4'hF, 1'b1, 1'b1};
    tv[4]  = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 32'h33333333, 4'hF, 1'b1, 1'b1};
    tv[5]  = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b0, 32'h33333333, 4'hF, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h33333333, 4'hF, 1'b1, 1'b1};
    tv[7]  = '{1'b1, 32'hB0B0B0B0, 4'h3, 1'b1, 1'b1, 1'b0, 32'h33333333, 4'hF, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 32'hC0C0C0C0, 4'hF, 1'b1, 1'b1, 1'b0, 32'h33333333, 4'hF, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0, 1'b1, 32'hA0A0A0A0, 4'hF, 1'b1, 1'b1};
    tv[10] = '{1'b0, 32'h00000000, 4'hF, 1'b1, 1'b0, 1'b1, 32'hA0A0A0A0, 4'hF, 1'b1, 1'b1};
    tv[11] = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b0, 1'b1, 32'hB0B0B0B0, 4'h3, 1'b1, 1'b1};
    tv[12] = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b1, 32'hB0B0B0B0, 4'h3, 1'b1, 1'b1};
    tv[13] = '{1'b0, 32'h00000000, 4'hF, 1'b0, 1'b1, 1'b0, 32'hB0B0B0B0, 4'h3, 1'b1, 1'b0};

    // reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLK); #1;
      check($sformatf("rst%0d_outs", i),
            {oWR_N, oDATA_OE, oREADY, oBUSY, oOE_N, oRD_N, oBE, oDATA},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 32'h0});
    end
    iRESET = 1'b0;
    #1 check("rel_ready_before_edge", oREADY, 1'b0);
    @(posedge iCLK); #1;
`ifdef USB_TX_PATTERN_EN
    check("rel_ready_pattern", oREADY, 1'b0);

    bx = xq.size();
    bb = bursts.size();
    c  = 0;
    while (bursts.size() - bb < 2 && c < 1000) begin
      @(posedge iCLK); #1;
      c++;
    end
    check("t7_two_bursts_seen", bursts.size() - bb >= 2, 1'b1);
    check("t7_burst0", bursts.size() > bb ? bursts[bb] : -1, 256);
    check("t7_burst1", bursts.size() > bb + 1 ? bursts[bb+1] : -1, 256);
    check("t7_count", xq.size() - bx >= 512, 1'b1);
    bad = 0;
    for (int i = 0; i < 512 && bx + i < xq.size(); i++)
      if (xq[bx+i] !== {4'hF, 32'(i)}) bad++;
    check("t7_pattern_order", bad, 0);
`else
    check("rel_ready", oREADY, 1'b1);

    // short packet, stall in IDLE, full buffer, stall in WRITE, partial BE
    for (int i = 0; i < 14; i++) begin
      iVALID = tv[i].v;
      iDATA  = tv[i].d;
      iBE    = tv[i].be;
      iTXE_N = tv[i].txe;
      @(posedge iCLK); #1;
      check($sformatf("vec%0d", i),
            {oWR_N, oDATA_OE, oREADY, oBUSY, oBE, oDATA},
            {tv[i].e_wr, tv[i].e_oe, tv[i].e_rdy, tv[i].e_busy, tv[i].e_be, tv[i].e_d});
    end
    iVALID = 1'b0;
    iTXE_N = 1'b0;

    // 600-word stream split into 256/256/88
    bx = xq.size();
    bb = bursts.size();
    bg = gaps.size();
    for (int i = 0; i < 600; i++) src_q.push_back({4'hF, 32'h10000000 + 32'(i)});
    drain(2000, ok);
    check("t3_drained", ok, 1'b1);
    check("t3_count", xq.size() - bx, 600);
    check("t3_nbursts", bursts.size() - bb, 3);
    check("t3_burst0", bursts.size() > bb ? bursts[bb] : -1, 256);
    check("t3_burst1", bursts.size() > bb + 1 ? bursts[bb+1] : -1, 256);
    check("t3_burst2", bursts.size() > bb + 2 ? bursts[bb+2] : -1, 88);
    check("t3_ngaps", gaps.size() - bg, 2);
    check("t3_gap0", gaps.size() > bg ? gaps[bg] : -1, 2);
    check("t3_gap1", gaps.size() > bg + 1 ? gaps[bg+1] : -1, 2);
    bad = 0;
    for (int i = 0; i < 600 && bx + i < xq.size(); i++)
      if (xq[bx+i] !== {4'hF, 32'h10000000 + 32'(i)}) bad++;
    check("t3_order", bad, 0);

    // 7-cycle TXE_N stall mid-burst
    bx = xq.size();
    for (int i = 0; i < 20; i++) src_q.push_back({4'hF, 32'h40000000 + 32'(i)});
    c = 0;
    while (xq.size() - bx < 5 && c < 100) begin
      cycle();
      c++;
    end
    check("t4_started", xq.size() - bx >= 5, 1'b1);
    nxt = xq.size() - bx;
    iTXE_N = 1'b1;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (oDATA !== 32'h40000000 + 32'(nxt) || oWR_N !== 1'b0 || oDATA_OE !== 1'b1) bad++;
    end
    check("t4_hold_stable", bad, 0);
    check("t4_no_xfer", xq.size() - bx, nxt);
    iTXE_N = 1'b0;
    drain(200, ok);
    check("t4_drained", ok, 1'b1);
    check("t4_count", xq.size() - bx, 20);
    bad = 0;
    for (int i = 0; i < 20 && bx + i < xq.size(); i++)
      if (xq[bx+i] !== {4'hF, 32'h40000000 + 32'(i)}) bad++;
    check("t4_order", bad, 0);

    // reset mid-burst at word 100
    bx = xq.size();
    for (int i = 0; i < 300; i++) src_q.push_back({4'hF, 32'h50000000 + 32'(i)});
    c = 0;
    while (xq.size() - bx < 100 && c < 500) begin
      cycle();
      c++;
    end
    check("t6_reached_100", xq.size() - bx >= 100, 1'b1);
    iRESET = 1'b1;
    iVALID = 1'b0;
    #1;
    check("t6_async_outs", {oWR_N, oDATA_OE, oREADY, oBUSY, oBE, oDATA},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
    src_q.delete();
    @(posedge iCLK); @(posedge iCLK); #1;
    iRESET = 1'b0;
    @(posedge iCLK); #1;
    bx = xq.size();
    bb = bursts.size();
    for (int i = 0; i < 3; i++) src_q.push_back({4'hF, 32'h60000000 + 32'(i)});
    drain(100, ok);
    check("t6_drained", ok, 1'b1);
    check("t6_count", xq.size() - bx, 3);
    bad = 0;
    for (int i = 0; i < 3 && bx + i < xq.size(); i++)
      if (xq[bx+i] !== {4'hF, 32'h60000000 + 32'(i)}) bad++;
    check("t6_fresh_data", bad, 0);
    check("t6_burst", bursts.size() > bb ? bursts[bb] : -1, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
